// File: rtl/rvfi_hang_sequencer_if.sv
// Handshake/status bundle between a hang-check sequencer and its environment.
// Carries the RVFI retirement inputs and the trig/check/progress outputs.
interface rvfi_hang_sequencer_if #(
    parameter int NRET  = 1,
    parameter int CNT_W = 8
);
    logic             enable;
    logic [NRET-1:0]  rvfi_valid;
    logic [NRET-1:0]  rvfi_halt;
    logic             trig;
    logic             check;
    logic             okay;
    logic             aborted;
    logic             done;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output enable, rvfi_valid, rvfi_halt,
        input  trig, check, okay, aborted, done, retire_count
    );

    modport slave (
        input  enable, rvfi_valid, rvfi_halt,
        output trig, check, okay, aborted, done, retire_count
    );
endinterface

// File: rtl/rvfi_hang_sequencer.sv
// Settle -> trig -> retirement window -> check sequencer for bounded-liveness checks.
// Counts RVFI retirements over the window and aborts if a halt retires inside it.
module rvfi_hang_sequencer #(
    parameter int NRET       = 1,
    parameter int SETTLE_CYC = 4,
    parameter int WINDOW_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    rvfi_hang_sequencer_if.slave  bus
);
    generate
        if (WINDOW_CYC < 1) begin : g_bad_window
            $error("rvfi_hang_sequencer: WINDOW_CYC must be >= 1");
        end
    endgenerate

    localparam int MAXC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(NRET + 1);
    localparam int SW   = ((CNT_W > PW) ? CNT_W : PW) + 1;

    // Window state lasts WINDOW_CYC-1 cycles so check lands WINDOW_CYC after trig.
    localparam logic [CW-1:0] SET_LAST =
        CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CW-1:0] WIN_LAST =
        CW'((WINDOW_CYC > 1) ? WINDOW_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIG,
        S_WINDOW,
        S_CHECK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             trig_q;
    logic             check_q;
    logic             okay_q;
    logic             aborted_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;

    logic [PW-1:0]    pop_d;
    logic [SW-1:0]    sum_d;
    logic [CNT_W-1:0] count_d;
    logic             halt_hit;
    logic             any_valid;

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < NRET; i++) begin
            pop_d = pop_d + PW'(bus.rvfi_valid[i]);
        end
        sum_d   = SW'(count_q) + SW'(pop_d);
        count_d = (sum_d > SW'(CMAX)) ? CMAX : CNT_W'(sum_d);
    end

    assign halt_hit  = |(bus.rvfi_valid & bus.rvfi_halt);
    assign any_valid = |bus.rvfi_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            check_q   <= 1'b0;
            okay_q    <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            trig_q  <= 1'b0;
            check_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (SETTLE_CYC == 0) begin
                        state_q <= S_TRIG;
                        trig_q  <= 1'b1;
                    end else begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.enable) begin
                        if (cnt_q == SET_LAST) begin
                            state_q <= S_TRIG;
                            trig_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_TRIG, S_WINDOW: begin
                    count_q <= count_d;
                    if (any_valid) okay_q <= 1'b1;
                    if (halt_hit) begin
                        state_q   <= S_ABORT;
                        aborted_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else if (state_q == S_TRIG) begin
                        cnt_q <= '0;
                        if (WINDOW_CYC == 1) begin
                            state_q <= S_CHECK;
                            check_q <= 1'b1;
                        end else begin
                            state_q <= S_WINDOW;
                        end
                    end else if (bus.enable) begin
                        if (cnt_q == WIN_LAST) begin
                            state_q <= S_CHECK;
                            check_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign bus.trig         = trig_q;
    assign bus.check        = check_q;
    assign bus.okay         = okay_q;
    assign bus.aborted      = aborted_q;
    assign bus.done         = done_q;
    assign bus.retire_count = count_q;
endmodule

// File: tb/tb_rvfi_hang_sequencer.sv
// Scoreboard bench: two sequencer configurations driven side by side,
// each against a behavioural phase model plus fixed timing expectations.
module tb_rvfi_hang_sequencer;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    rvfi_hang_sequencer_if #(.NRET(1), .CNT_W(8)) b0 ();
    rvfi_hang_sequencer_if #(.NRET(2), .CNT_W(4)) b1 ();

    rvfi_hang_sequencer #(
        .NRET(1), .SETTLE_CYC(4), .WINDOW_CYC(16), .CNT_W(8)
    ) u_d0 (
        .clock(clk), .reset(rst0), .bus(b0)
    );

    rvfi_hang_sequencer #(
        .NRET(2), .SETTLE_CYC(4), .WINDOW_CYC(20), .CNT_W(4)
    ) u_d1 (
        .clock(clk), .reset(rst1), .bus(b1)
    );

    int n_vec = 0;
    int n_err = 0;

    // stimulus per DUT
    bit       r_in [2];
    bit       e_in [2];
    bit [1:0] v_in [2];
    bit [1:0] h_in [2];

    // phase model: 0 idle 1 settle 2 trig 3 window 4 check 5 done 6 abort
    int ph [2];
    int left [2];
    int mc [2];
    bit mok [2];

    // event tracking per reset epoch
    int trig_at [2];
    int check_at [2];
    int abort_at [2];
    int n_trig [2];
    int n_check [2];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mstep(input int k, input bit r, input bit e,
                         input int nv, input bit hh, input int st,
                         input int win, input int mx);
        if (r) begin
            ph[k] = 0;
            left[k] = 0;
            mc[k] = 0;
            mok[k] = 1'b0;
            return;
        end
        case (ph[k])
            0: begin
                if (st == 0) ph[k] = 2;
                else begin
                    ph[k] = 1;
                    left[k] = st;
                end
            end
            1: begin
                if (e) begin
                    left[k]--;
                    if (left[k] == 0) ph[k] = 2;
                end
            end
            2, 3: begin
                mc[k] = (mc[k] + nv > mx) ? mx : mc[k] + nv;
                if (nv > 0) mok[k] = 1'b1;
                if (hh) ph[k] = 6;
                else if (ph[k] == 2) begin
                    left[k] = win - 1;
                    ph[k] = (left[k] == 0) ? 4 : 3;
                end else if (e) begin
                    left[k]--;
                    if (left[k] == 0) ph[k] = 4;
                end
            end
            4: ph[k] = 5;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] mexp(input int k);
        logic [31:0] x;
        x = '0;
        x[12] = (ph[k] == 2);
        x[11] = (ph[k] == 4);
        x[10] = mok[k];
        x[9]  = (ph[k] == 6);
        x[8]  = (ph[k] >= 5);
        x[7:0] = 8'(mc[k]);
        return x;
    endfunction

    function automatic logic [31:0] obs0();
        return {19'd0, b0.trig, b0.check, b0.okay, b0.aborted,
                b0.done, b0.retire_count};
    endfunction

    function automatic logic [31:0] obs1();
        return {19'd0, b1.trig, b1.check, b1.okay, b1.aborted,
                b1.done, 4'd0, b1.retire_count};
    endfunction

    task automatic clr_track(input int k);
        trig_at[k] = -1;
        check_at[k] = -1;
        abort_at[k] = -1;
        n_trig[k] = 0;
        n_check[k] = 0;
    endtask

    task automatic track(input int k, input int c, input logic t,
                         input logic ck, input logic ab);
        if (t) begin
            trig_at[k] = c;
            n_trig[k]++;
        end
        if (ck) begin
            check_at[k] = c;
            n_check[k]++;
        end
        if (ab && abort_at[k] < 0) abort_at[k] = c;
    endtask

    task automatic cyc(input int c);
        int nv0;
        int nv1;
        @(negedge clk);
        rst0 = r_in[0];
        rst1 = r_in[1];
        b0.enable = e_in[0];
        b1.enable = e_in[1];
        b0.rvfi_valid = v_in[0][0:0];
        b0.rvfi_halt  = h_in[0][0:0];
        b1.rvfi_valid = v_in[1];
        b1.rvfi_halt  = h_in[1];
        nv0 = int'(v_in[0][0]);
        nv1 = int'(v_in[1][0]) + int'(v_in[1][1]);
        mstep(0, r_in[0], e_in[0], nv0, v_in[0][0] & h_in[0][0], 4, 16, 255);
        mstep(1, r_in[1], e_in[1], nv1, |(v_in[1] & h_in[1]), 4, 20, 15);
        q0.push_back(mexp(0));
        q1.push_back(mexp(1));
        @(posedge clk);
        #1;
        if (r_in[0]) clr_track(0);
        if (r_in[1]) clr_track(1);
        chk($sformatf("d0 c%0d", c), obs0(), q0.pop_front());
        chk($sformatf("d1 c%0d", c), obs1(), q1.pop_front());
        chk("d0 inv", {30'd0, b0.trig & b0.check, b0.check & b0.aborted}, 0);
        chk("d1 inv", {30'd0, b1.trig & b1.check, b1.check & b1.aborted}, 0);
        track(0, c, b0.trig, b0.check, b0.aborted);
        track(1, c, b1.trig, b1.check, b1.aborted);
    endtask

    task automatic idle_in();
        for (int k = 0; k < 2; k++) begin
            r_in[k] = 1'b0;
            e_in[k] = 1'b1;
            v_in[k] = 2'b00;
            h_in[k] = 2'b00;
        end
    endtask

    task automatic both_reset();
        idle_in();
        r_in[0] = 1'b1;
        r_in[1] = 1'b1;
        cyc(0);
        cyc(0);
        chk("rst d0", obs0(), 0);
        chk("rst d1", obs1(), 0);
        r_in[0] = 1'b0;
        r_in[1] = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.enable = 1'b0;
        b1.enable = 1'b0;
        b0.rvfi_valid = '0;
        b0.rvfi_halt  = '0;
        b1.rvfi_valid = '0;
        b1.rvfi_halt  = '0;
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0;
            left[k] = 0;
            mc[k] = 0;
            mok[k] = 1'b0;
            clr_track(k);
        end

        // d0: valid every 3rd cycle; d1: no retirements at all
        both_reset();
        for (int c = 1; c <= 30; c++) begin
            v_in[0] = (c % 3 == 0) ? 2'b01 : 2'b00;
            cyc(c);
        end
        chk("t1 trig", trig_at[0], 5);
        chk("t1 check", check_at[0], 21);
        chk("t1 count", b0.retire_count, 6);
        chk("t1 okay", b0.okay, 1);
        chk("t1 done", b0.done, 1);
        chk("t1 pulses", {n_trig[0][15:0], n_check[0][15:0]}, 32'h0001_0001);
        chk("t2 check", check_at[1], 25);
        chk("t2 okay", b1.okay, 0);
        chk("t2 count", b1.retire_count, 0);
        chk("t2 aborted", b1.aborted, 0);

        // d0: enable low 5 cycles mid-window; d1: both channels every cycle
        both_reset();
        for (int c = 1; c <= 35; c++) begin
            e_in[0] = !(c >= 10 && c <= 14);
            v_in[0] = 2'b01;
            v_in[1] = 2'b11;
            cyc(c);
        end
        chk("t5 check", check_at[0], 26);
        chk("t5 count", b0.retire_count, 21);
        chk("t3 check", check_at[1], 25);
        chk("t3 sat", b1.retire_count, 15);

        // d0: reset mid-window; d1: halt on ch1 in window cycle 7
        both_reset();
        for (int c = 1; c <= 36; c++) begin
            r_in[0] = (c == 10);
            v_in[0] = 2'b01;
            v_in[1] = (c == 13) ? 2'b11 : 2'b01;
            h_in[1] = (c == 13) ? 2'b10 : 2'b00;
            cyc(c);
            if (c == 10) chk("t6 rst", obs0(), 0);
        end
        chk("t6 retrig", trig_at[0], 15);
        chk("t6 check", check_at[0], 31);
        chk("t6 ntrig", n_trig[0], 1);
        chk("t4 abort", abort_at[1], 13);
        chk("t4 nocheck", n_check[1], 0);
        chk("t4 count", b1.retire_count, 9);
        chk("t4 done", {b1.done, b1.aborted}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
